// File: rtl/apb_regfile_slave.sv
// apb_regfile_slave: APB register file with byte strobes, wait states and read-only status registers.
// Transfer fields are latched at setup, so they cannot change during an access.
module apb_regfile_slave #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_REGS = 8,
    parameter int WAIT_STATES = 0,
    parameter logic [NUM_REGS-1:0] RO_MASK = '0
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic [ADDR_WIDTH-1:0]          PADDR,
    input  logic                           PSELx,
    input  logic                           PENABLE,
    input  logic                           PWRITE,
    input  logic [DATA_WIDTH-1:0]          PWDATA,
    input  logic [DATA_WIDTH/8-1:0]        PSTRB,
    output logic [DATA_WIDTH-1:0]          PRDATA,
    output logic                           PREADY,
    output logic                           PSLVERR,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] i_status,
    output logic [NUM_REGS*DATA_WIDTH-1:0] o_regs
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int LB = $clog2(BYTES);
    localparam int IW = $clog2(NUM_REGS);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t state = IDLE;
    logic [3:0] cnt = '0;
    logic [ADDR_WIDTH-1:0] addr_q = '0;
    logic write_q = 1'b0;
    logic [DATA_WIDTH-1:0] wdata_q = '0;
    logic [BYTES-1:0] strb_q = '0;
    logic [DATA_WIDTH-1:0] prdata_q = '0;
    logic pready_q = 1'b0;
    logic pslverr_q = 1'b0;
    logic [DATA_WIDTH-1:0] mem [NUM_REGS] = '{default: '0};

    logic setup, enter_done, valid, ro, err, ewrite;
    logic [ADDR_WIDTH-1:0] eaddr;
    logic [DATA_WIDTH-1:0] ewdata, rdval;
    logic [BYTES-1:0] estrb;
    logic [IW-1:0] idx;

    // With no wait states the commit edge is the setup edge, so the live bus is used.
    always_comb begin
        setup = state == IDLE && PSELx && !PENABLE;
        eaddr = state == IDLE ? PADDR : addr_q;
        ewrite = state == IDLE ? PWRITE : write_q;
        ewdata = state == IDLE ? PWDATA : wdata_q;
        estrb = state == IDLE ? PSTRB : strb_q;
        idx = eaddr[LB +: IW];
        valid = (eaddr & ADDR_WIDTH'(BYTES - 1)) == '0 && (eaddr >> (LB + IW)) == '0;
        ro = RO_MASK[idx];
        err = !valid || (ewrite && ro && |estrb);
        rdval = ro ? i_status[int'(idx) * DATA_WIDTH +: DATA_WIDTH] : mem[idx];
        enter_done = (setup && WAIT_STATES == 0) || (state == WAIT && PSELx && cnt == '0);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= IDLE;
            cnt <= '0;
            pready_q <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q <= '0;
            for (int r = 0; r < NUM_REGS; r++) mem[r] <= '0;
        end else begin
            pready_q <= enter_done;
            pslverr_q <= enter_done && err;
            prdata_q <= (enter_done && !err && !ewrite) ? rdval : '0;
            if (enter_done && !err && ewrite)
                for (int b = 0; b < BYTES; b++)
                    if (estrb[b]) mem[idx][b*8 +: 8] <= ewdata[b*8 +: 8];
            if (setup) begin
                addr_q <= PADDR;
                write_q <= PWRITE;
                wdata_q <= PWDATA;
                strb_q <= PSTRB;
            end
            case (state)
                IDLE: if (setup) begin
                    state <= WAIT_STATES == 0 ? DONE : WAIT;
                    cnt <= 4'(WAIT_STATES - 1);
                end
                WAIT: if (!PSELx) state <= IDLE;
                      else if (cnt == '0) state <= DONE;
                      else cnt <= cnt - 4'd1;
                default: state <= IDLE;
            endcase
        end
    end

    assign PRDATA = prdata_q;
    assign PREADY = pready_q;
    assign PSLVERR = pslverr_q;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_out
        assign o_regs[i*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[i] ? '0 : mem[i];
    end
endmodule

// File: tb/tb_apb_regfile_slave.sv
// tb_apb_regfile_slave: directed APB transfers with hand-computed expectations.
module tb_apb_regfile_slave;
    logic i_clk = 1'b0;
    logic i_reset = 1'b1;
    logic [31:0] PADDR = '0;
    logic PSELx = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
    logic [31:0] PWDATA = '0;
    logic [3:0] PSTRB = '0;
    logic [31:0] PRDATA;
    logic PREADY, PSLVERR;
    logic [255:0] i_status = '0;
    logic [255:0] o_regs;
    int n_cmp = 0, n_bad = 0, cyc = 0;

    apb_regfile_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_REGS(8), .WAIT_STATES(2), .RO_MASK(8'h80)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .PADDR(PADDR), .PSELx(PSELx), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY),
        .PSLVERR(PSLVERR), .i_status(i_status), .o_regs(o_regs)
    );

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Runs one transfer; PWDATA is corrupted after setup to prove it was latched.
    task automatic apb(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] s,
                       output logic [31:0] rd, output logic er, output int n, output int t);
        @(posedge i_clk); #1;
        PSELx = 1; PENABLE = 0; PADDR = a; PWRITE = w; PWDATA = d; PSTRB = s;
        n = 0;
        do begin
            @(posedge i_clk); #1;
            if (n == 0) begin
                PENABLE = 1;
                PWDATA = ~d;
            end
            n++;
            if (!PREADY) begin
                chk("idle_prdata", PRDATA, 0);
                chk("idle_slverr", PSLVERR, 0);
            end
        end while (!PREADY && n < 20);
        if (n >= 20) chk("timeout", 1, 0);
        rd = PRDATA; er = PSLVERR; t = cyc;
        PSELx = 0; PENABLE = 0;
    endtask

    function automatic logic [31:0] reg_of(input int i);
        return o_regs[i*32 +: 32];
    endfunction

    logic [31:0] rd;
    logic er;
    int n, t0, t1, seen;

    initial begin
        i_status[7*32 +: 32] = 32'h5A5A5A5A;
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_pready", PREADY, 0);
        chk("rst_slverr", PSLVERR, 0);
        chk("rst_prdata", PRDATA, 0);
        chk("rst_regs", o_regs, 0);
        i_reset = 0;

        apb(32'h04, 1, 32'hDEADBEEF, 4'hF, rd, er, n, t0);
        chk("wr4_cycles", n, 3);
        chk("wr4_err", er, 0);
        chk("wr4_prdata", rd, 0);
        apb(32'h04, 0, 0, 4'h0, rd, er, n, t0);
        chk("rd4_cycles", n, 3);
        chk("rd4_err", er, 0);
        chk("rd4_data", rd, 32'hDEADBEEF);
        chk("reg1", reg_of(1), 32'hDEADBEEF);

        apb(32'h08, 1, 32'h11223344, 4'hF, rd, er, n, t0);
        apb(32'h08, 1, 32'hAABBCCDD, 4'b0101, rd, er, n, t0);
        chk("strb_err", er, 0);
        chk("reg2_strb", reg_of(2), 32'h11BB33DD);

        apb(32'h1C, 1, 32'h12345678, 4'hF, rd, er, n, t0);
        chk("ro_wr_err", er, 1);
        chk("reg7_out", reg_of(7), 0);
        apb(32'h1C, 0, 0, 4'h0, rd, er, n, t0);
        chk("ro_rd_err", er, 0);
        chk("ro_rd_data", rd, 32'h5A5A5A5A);
        apb(32'h1C, 1, 32'h12345678, 4'h0, rd, er, n, t0);
        chk("ro_zstrb_err", er, 0);

        apb(32'h20, 0, 0, 4'h0, rd, er, n, t0);
        chk("oob_err", er, 1);
        chk("oob_data", rd, 0);
        apb(32'h06, 1, 32'hFFFFFFFF, 4'hF, rd, er, n, t0);
        chk("mis_err", er, 1);
        chk("mis_data", rd, 0);
        chk("mis_reg1", reg_of(1), 32'hDEADBEEF);

        apb(32'h04, 1, 32'h0000FFFF, 4'h0, rd, er, n, t0);
        chk("zstrb_err", er, 0);
        chk("zstrb_reg1", reg_of(1), 32'hDEADBEEF);

        // Abort: select drops during the wait states.
        @(posedge i_clk); #1;
        PSELx = 1; PENABLE = 0; PADDR = 32'h0C; PWRITE = 1; PWDATA = 32'h0BADF00D; PSTRB = 4'hF;
        @(posedge i_clk); #1;
        PENABLE = 1;
        @(posedge i_clk); #1;
        PSELx = 0; PENABLE = 0;
        seen = 0;
        repeat (5) begin
            @(posedge i_clk); #1;
            if (PREADY || PSLVERR) seen++;
        end
        chk("abort_ready", seen, 0);
        chk("abort_reg3", reg_of(3), 0);

        // Access phase without setup is ignored.
        PSELx = 1; PENABLE = 1; PADDR = 32'h0C; PWRITE = 1;
        seen = 0;
        repeat (4) begin
            @(posedge i_clk); #1;
            if (PREADY) seen++;
        end
        PSELx = 0; PENABLE = 0;
        chk("noset_ready", seen, 0);
        chk("noset_reg3", reg_of(3), 0);

        // Reset during a wait state abandons the pending write.
        @(posedge i_clk); #1;
        PSELx = 1; PENABLE = 0; PADDR = 32'h00; PWRITE = 1; PWDATA = 32'hFFFFFFFF; PSTRB = 4'hF;
        @(posedge i_clk); #1;
        PENABLE = 1; i_reset = 1;
        seen = 0;
        @(posedge i_clk); #1;
        if (PREADY) seen++;
        i_reset = 0; PSELx = 0; PENABLE = 0;
        repeat (5) begin
            @(posedge i_clk); #1;
            if (PREADY) seen++;
        end
        chk("rstw_ready", seen, 0);
        chk("rstw_reg0", reg_of(0), 0);
        chk("rstw_reg1", reg_of(1), 0);

        apb(32'h04, 1, 32'hCAFEF00D, 4'hF, rd, er, n, t0);
        apb(32'h00, 0, 0, 4'h0, rd, er, n, t0);
        chk("b2b_rd0", rd, 0);
        apb(32'h04, 0, 0, 4'h0, rd, er, n, t1);
        chk("b2b_rd1", rd, 32'hCAFEF00D);
        chk("b2b_gap", t1 - t0, 4);

        @(posedge i_clk); #1;
        chk("end_prdata", PRDATA, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/apb_regfile_slave.md
APB_REGFILE_SLAVE -- requirements
Module: apb_regfile_slave

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 32, the data bus width; legal values 8, 16, 32, 64.
REQ-002 SHALL provide parameter ADDR_WIDTH, default 32, the PADDR width.
REQ-003 SHALL provide parameter NUM_REGS, default 8, the register count; must be a power of 2 and at least 2.
REQ-004 SHALL provide parameter WAIT_STATES, default 0, the PREADY-low access cycles per transfer; legal range 0..15.
REQ-005 SHALL provide parameter RO_MASK, default all zeros, NUM_REGS bits wide; bit i set makes register i read-only (status).
REQ-006 SHALL have these ports (one clock; reset is synchronous and active-high):
- i_clk  in  1  APB clock; all logic on the rising edge.
- i_reset  in  1  synchronous active-high reset.
- PADDR  in  ADDR_WIDTH  byte address.
- PSELx  in  1  slave select.
- PENABLE  in  1  access phase.
- PWRITE  in  1  1 = write, 0 = read.
- PWDATA  in  DATA_WIDTH  write data.
- PSTRB  in  DATA_WIDTH/8  write byte-lane strobes.
- PRDATA  out  DATA_WIDTH  read data.
- PREADY  out  1  transfer complete.
- PSLVERR  out  1  transfer error; valid only while PREADY=1.
- i_status  in  NUM_REGS*DATA_WIDTH  read-only register sources; slice i is register i.
- o_regs  out  NUM_REGS*DATA_WIDTH  current register contents, flattened; slice i is register i.

Function
REQ-007 SHALL decode register index = PADDR >> log2(DATA_WIDTH/8).
- Address valid iff the low log2(DATA_WIDTH/8) bits are 0 and PADDR < NUM_REGS*(DATA_WIDTH/8).
REQ-008 SHALL use FSM states IDLE, WAIT and DONE.
- IDLE -> WAIT on PSELx=1, PENABLE=0 (setup) when WAIT_STATES>0; IDLE -> DONE on setup when WAIT_STATES=0.
- WAIT -> DONE after WAIT_STATES cycles.
- DONE -> IDLE always.
REQ-009 SHALL register PREADY and drive it high only in DONE; the PREADY cycle is access cycle WAIT_STATES+1 after setup.
REQ-010 SHALL sample PADDR, PWRITE, PWDATA and PSTRB at the setup edge and ignore later changes within the transfer.
REQ-011 SHALL abort to IDLE with no register update, PREADY=0 and PSLVERR=0 if PSELx falls in WAIT.
REQ-012 SHALL commit a valid write at the edge entering DONE, updating only byte lanes whose PSTRB bit is 1; all-zero PSTRB updates nothing and is not an error.
REQ-013 SHALL, on a read, load PRDATA at the edge entering DONE.
- RW register: register value.
- RO register: the i_status slice, sampled at that edge.
REQ-014 SHALL drive PRDATA = 0 in every cycle except the DONE cycle of a successful read.
REQ-015 SHALL assert PSLVERR in DONE, with no register change, for:
- an invalid address (read or write);
- a write with nonzero PSTRB to a register whose RO_MASK bit is set.
REQ-016 SHALL hold PSLVERR at 0 whenever PREADY is 0.
REQ-017 SHALL drive o_regs slice i = 0 for RO registers and the stored value for RW registers; updates are visible the cycle after commit.
REQ-018 SHALL support back-to-back transfers: a setup in the cycle after DONE starts a new transfer with no idle gap.
REQ-019 SHALL ignore PENABLE=1 while in IDLE without a preceding setup cycle (protocol violation: no state change).

Reset
REQ-020 SHALL, while i_reset=1 at a rising edge, set FSM to IDLE, PREADY=0, PSLVERR=0, PRDATA=0 and every RW register to 0.
REQ-021 SHALL give i_reset priority over all transfer activity; reset during WAIT or DONE abandons the transfer, including any pending write.
REQ-022 SHALL have initial values equal to the reset values.

Verification (DATA_WIDTH=32, NUM_REGS=8, WAIT_STATES=2, RO_MASK=8'h80)
REQ-023 SHALL cover a write of 0xDEADBEEF to 0x04 with PSTRB=4'hF, then a read of 0x04 -> PREADY high in the 3rd access cycle, PSLVERR=0, PRDATA=0xDEADBEEF.
REQ-024 SHALL cover reg 2 = 0x11223344, then a write of 0xAABBCCDD to 0x08 with PSTRB=4'b0101 -> reg 2 = 0x11BB33DD.
REQ-025 SHALL cover a write to 0x1C (RO) with PSTRB=4'hF and i_status[7]=0x5A5A5A5A -> PSLVERR=1, then a read of 0x1C returns 0x5A5A5A5A.
REQ-026 SHALL cover a read of 0x20 and a write to 0x06 -> PSLVERR=1 and PRDATA=0 on both, no register change.
REQ-027 SHALL cover i_reset=1 in WAIT of a write of 0xFFFFFFFF to 0x00 -> reg 0 stays 0 and PREADY never asserts.
REQ-028 SHALL cover two back-to-back reads of 0x00 and 0x04 -> two PREADY pulses exactly 4 cycles apart.
